umi_rr_arbiter: RTL and testbench
=================================

# umi_rr_arbiter

Round-robin arbiter merging N independent UMI streams onto one UMI output port, with message-level locking on the EOM bit so multi-transaction messages are never interleaved. It sits upstream of `umi_splitter` wherever several requesters share one UMI link, and is exercised in switchboard with one `QUEUE_TO_UMI_SIM` per input and a single `UMI_TO_QUEUE_SIM` on the output.

## Interface
- `N`, 2 — number of input streams, 1..16
- `DW`, 256 — UMI data width
- `AW`, 64 — UMI address width
- `CW`, 32 — UMI command width
- `clk` input 1 — clock, all logic on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `umi_in_valid` input N — per-input valid
- `umi_in_cmd` input N*CW — input i at `[i*CW +: CW]`
- `umi_in_dstaddr` input N*AW — input i at `[i*AW +: AW]`
- `umi_in_srcaddr` input N*AW — input i at `[i*AW +: AW]`
- `umi_in_data` input N*DW — input i at `[i*DW +: DW]`
- `umi_in_ready` output N — per-input ready
- `umi_out_valid` output 1
- `umi_out_cmd` output CW
- `umi_out_dstaddr` output AW
- `umi_out_srcaddr` output AW
- `umi_out_data` output DW
- `umi_out_ready` input 1
- `grant_id` output max(1,$clog2(N)) — index of the input currently selected, for debug and probes

## Operation
- A transfer on any port occurs on a cycle where valid and ready are both high. Fields are passed unmodified.
- EOM is `cmd[22]`.
- State:
  - `ptr`: highest-priority index, reset 0.
  - `locked`: reset 0.
  - `lock_id`: reset 0.
- **Unlocked:**
  - Grant goes to the first input with valid high, scanning `ptr, ptr+1, ..., ptr+N-1` mod N.
  - If no input is valid, there is no grant and `umi_out_valid` is 0.
- **Locked:** grant is `lock_id` only. Other inputs see ready 0 even when the output is idle.
- **On each accepted input beat:**
  - EOM=0: set `locked=1` and `lock_id` to the granted index.
  - EOM=1: set `locked=0` and `ptr=(granted index+1) mod N`.
- `ptr` changes only at message end. Single-beat messages (EOM=1) rotate priority every beat.
- `umi_in_ready[i]` is high only for the granted input, only when the output stage can accept. All other bits are 0.
- Input valid is never combinationally dependent on ready. The arbiter never drops valid once asserted downstream; the output holds until taken.
- N=1: pass-through; `ptr` and `grant_id` are constant 0.
- **Reset mid-message:** lock cleared, `ptr`=0, any partially sent message is abandoned. Upstream resets concurrently.

## Timing
- All state updates on rising `clk`.
- `rst` clears state asynchronously, with synchronous deassertion assumed from the system.
- **Reset values:**
  - `umi_out_valid` 0.
  - `umi_in_ready` all 0.
  - `grant_id` 0.
  - Output payload 0 with `UMI_ARB_OUTREG_EN`; otherwise a combinational mux of input 0.
- **Without `UMI_ARB_OUTREG_EN`:**
  - Zero latency: output equals the granted input the same cycle.
  - `umi_in_ready[g] = umi_out_ready`.
- **With `UMI_ARB_OUTREG_EN`:**
  - One-cycle latency.
  - Accept when `!out_full || umi_out_ready`, giving full throughput of 1 beat/cycle.
  - Arbitration (including the lock/ptr update) happens at input acceptance, not output drain.
- Back-to-back messages from different inputs: no bubble cycle required at a message boundary.

## Configuration
- `UMI_ARB_OUTREG_EN` defined: output register stage on all `umi_out_*` signals.
  - `umi_out_*` driven from flops.
  - `umi_in_ready` depends only on flop state and `umi_out_ready`.
- Undefined: purely combinational datapath; `umi_out_ready` to `umi_in_ready` is a combinational path.
- Arbitration order and message locking are identical in both builds; only latency differs.

## Test plan
- **Round-robin, N=2:**
  - Stimulus: both inputs continuously valid with single-beat EOM=1 packets, `umi_out_ready`=1.
  - Required: output alternates in0, in1, in0, ... with no idle cycles; 100 beats give 50/50.
- **Message lock:**
  - Stimulus: in0 sends 3 beats (EOM 0,0,1) while in1 is valid throughout.
  - Required: 3 in0 beats appear contiguous, then in1; `umi_in_ready[1]`=0 during the lock.
- **Backpressure:**
  - Stimulus: `umi_out_ready` toggled at random 50%.
  - Required: all payloads (dstaddr = sequence number per input) arrive in per-input order, none lost or duplicated, stable while stalled.
- **Idle within lock:**
  - Stimulus: in0 drops valid for 5 cycles mid-message while in1 is valid.
  - Required: no in1 beat is emitted until the in0 EOM beat.
- **Reset mid-message:**
  - Stimulus: assert `rst` after beat 1 of a 3-beat in1 message.
  - Required: outputs go to reset values immediately; after release, in0 wins first (`ptr`=0).
- **N=4 fairness:**
  - Stimulus: inputs 1 and 3 only valid.
  - Required: alternation 1, 3, 1, 3; `grant_id` matches each beat's source.

Source files
------------

// File: rtl/umi_rr_arbiter.sv
// Round-robin UMI arbiter with EOM-based message locking (cmd[22]).
// Define UMI_ARB_OUTREG_EN to register all umi_out_* signals (one cycle latency).
module umi_rr_arbiter #(
  parameter int N  = 2,
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         umi_in_valid,
  input  logic [N*CW-1:0]                      umi_in_cmd,
  input  logic [N*AW-1:0]                      umi_in_dstaddr,
  input  logic [N*AW-1:0]                      umi_in_srcaddr,
  input  logic [N*DW-1:0]                      umi_in_data,
  output logic [N-1:0]                         umi_in_ready,
  output logic                                 umi_out_valid,
  output logic [CW-1:0]                        umi_out_cmd,
  output logic [AW-1:0]                        umi_out_dstaddr,
  output logic [AW-1:0]                        umi_out_srcaddr,
  output logic [DW-1:0]                        umi_out_data,
  input  logic                                 umi_out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);

  localparam int GW  = (N > 1) ? $clog2(N) : 1;
  localparam int EOM = 22;

  logic [GW-1:0] r_ptr;
  logic [GW-1:0] r_lock_id;
  logic          r_locked;

  logic [GW-1:0] w_sel;
  logic [GW-1:0] w_idx;
  logic [GW-1:0] w_ptr_nxt;
  logic          w_gnt;
  logic          w_can;
  logic          w_fire;
  logic [CW-1:0] w_cmd;
  logic [AW-1:0] w_dst;
  logic [AW-1:0] w_src;
  logic [DW-1:0] w_data;

  // Selection is forced to input 0 with no grant while reset is asserted.
  always_comb begin
    w_sel = '0;
    w_gnt = 1'b0;
    w_idx = '0;
    if (!rst) begin
      w_sel = r_ptr;
      if (r_locked) begin
        w_sel = r_lock_id;
        w_gnt = umi_in_valid[r_lock_id];
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          w_idx = GW'((32'(r_ptr) + k) % N);
          if (!w_gnt && umi_in_valid[w_idx]) begin
            w_gnt = 1'b1;
            w_sel = w_idx;
          end
        end
      end
    end
  end

  assign w_cmd     = umi_in_cmd[w_sel*CW +: CW];
  assign w_dst     = umi_in_dstaddr[w_sel*AW +: AW];
  assign w_src     = umi_in_srcaddr[w_sel*AW +: AW];
  assign w_data    = umi_in_data[w_sel*DW +: DW];
  assign w_ptr_nxt = (32'(w_sel) == N - 1) ? '0 : w_sel + 1'b1;
  assign w_fire    = w_gnt && w_can;

  always_comb begin
    umi_in_ready = '0;
    if (w_fire) umi_in_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_fire) begin
      if (w_cmd[EOM]) begin
        r_locked <= 1'b0;
        r_ptr    <= w_ptr_nxt;
      end else begin
        r_locked  <= 1'b1;
        r_lock_id <= w_sel;
      end
    end
  end

`ifdef UMI_ARB_OUTREG_EN
  logic          r_full;
  logic [CW-1:0] r_cmd;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_src;
  logic [DW-1:0] r_data;
  logic [GW-1:0] r_gid;

  assign w_can = !r_full || umi_out_ready;

  // grant_id tracks the source of the beat held in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_cmd  <= '0;
      r_dst  <= '0;
      r_src  <= '0;
      r_data <= '0;
      r_gid  <= '0;
    end else if (w_fire) begin
      r_full <= 1'b1;
      r_cmd  <= w_cmd;
      r_dst  <= w_dst;
      r_src  <= w_src;
      r_data <= w_data;
      r_gid  <= w_sel;
    end else if (umi_out_ready) begin
      r_full <= 1'b0;
    end
  end

  assign umi_out_valid   = r_full;
  assign umi_out_cmd     = r_cmd;
  assign umi_out_dstaddr = r_dst;
  assign umi_out_srcaddr = r_src;
  assign umi_out_data    = r_data;
  assign grant_id        = r_gid;
`else
  assign w_can           = umi_out_ready;
  assign umi_out_valid   = w_gnt;
  assign umi_out_cmd     = w_cmd;
  assign umi_out_dstaddr = w_dst;
  assign umi_out_srcaddr = w_src;
  assign umi_out_data    = w_data;
  assign grant_id        = w_sel;
`endif

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Scoreboard bench for umi_rr_arbiter (default build): N=2 and N=4 instances.
module tb_umi_rr_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      v2, r2;
  logic [2*CW-1:0] c2;
  logic [2*AW-1:0] d2, s2;
  logic [2*DW-1:0] x2;
  logic            ov2, ordy2, gid2;
  logic [CW-1:0]   oc2;
  logic [AW-1:0]   od2, os2;
  logic [DW-1:0]   ox2;

  logic [3:0]      v4, r4;
  logic [4*CW-1:0] c4;
  logic [4*AW-1:0] d4, s4;
  logic [4*DW-1:0] x4;
  logic            ov4, ordy4;
  logic [1:0]      gid4;
  logic [CW-1:0]   oc4;
  logic [AW-1:0]   od4, os4;
  logic [DW-1:0]   ox4;

  umi_rr_arbiter #(.N(2), .DW(DW), .AW(AW), .CW(CW)) u_dut2 (
    .clk(clk), .rst(rst),
    .umi_in_valid(v2), .umi_in_cmd(c2), .umi_in_dstaddr(d2), .umi_in_srcaddr(s2),
    .umi_in_data(x2), .umi_in_ready(r2),
    .umi_out_valid(ov2), .umi_out_cmd(oc2), .umi_out_dstaddr(od2), .umi_out_srcaddr(os2),
    .umi_out_data(ox2), .umi_out_ready(ordy2), .grant_id(gid2)
  );

  umi_rr_arbiter #(.N(4), .DW(DW), .AW(AW), .CW(CW)) u_dut4 (
    .clk(clk), .rst(rst),
    .umi_in_valid(v4), .umi_in_cmd(c4), .umi_in_dstaddr(d4), .umi_in_srcaddr(s4),
    .umi_in_data(x4), .umi_in_ready(r4),
    .umi_out_valid(ov4), .umi_out_cmd(oc4), .umi_out_dstaddr(od4), .umi_out_srcaddr(os4),
    .umi_out_data(ox4), .umi_out_ready(ordy4), .grant_id(gid4)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exq[$];
  int    exq4[$];

  int n_vec = 0;
  int n_err = 0;
  int seq[2];
  int cnt[2];
  int m_ptr, m_lid, last_src, used;
  bit m_locked, rnd, have_stall, f;
  logic [AW-1:0] stall_dst;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] src_of(input logic [AW-1:0] d);
    return d ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] d);
    return ~d;
  endfunction

  task automatic push_beat(input int i, input bit eom);
    beat_t b;
    b.cmd = 32'h0000_0004 | (eom ? 32'h0040_0000 : 32'h0) | (32'(i) << 8);
    b.dst = (32'(i) << 16) | 32'(seq[i]);
    seq[i]++;
    if (i == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic push_msg(input int i, input int len);
    for (int b = 0; b < len; b++) push_beat(i, b == len - 1);
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      beat_t h;
      bit has;
      h = '{default: '0};
      has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (has) h = (i == 0) ? q0[0] : q1[0];
      v2[i]            = has;
      c2[i*CW +: CW]   = h.cmd;
      d2[i*AW +: AW]   = h.dst;
      s2[i*AW +: AW]   = src_of(h.dst);
      x2[i*DW +: DW]   = data_of(h.dst);
    end
    ordy2 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock of the N=2 scoreboard: model grant, push expected, compare output.
  task automatic cycle(output bit fired);
    bit    gv;
    int    g;
    beat_t h, e;
    drive();
    @(negedge clk);
    gv = 1'b0;
    g  = 0;
    if (m_locked) begin
      g  = m_lid;
      gv = v2[g];
    end else if (v2[m_ptr]) begin
      g  = m_ptr;
      gv = 1'b1;
    end else if (v2[1-m_ptr]) begin
      g  = 1 - m_ptr;
      gv = 1'b1;
    end
    check("out_valid", ov2, gv);
    check("in_ready", r2, (gv && ordy2) ? (2'b01 << g) : 2'b00);
    if (gv) check("grant_id", gid2, g);
    if (have_stall) check("stall_hold", od2, stall_dst);
    have_stall = ov2 && !ordy2;
    stall_dst  = od2;
    fired = gv && ordy2;
    if (fired) begin
      h = (g == 0) ? q0[0] : q1[0];
      exq.push_back(h);
    end
    if (ov2 && ordy2) begin
      check("sb_nonempty", exq.size() > 0, 1'b1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        check("out_dst", od2, e.dst);
        check("out_cmd", oc2, e.cmd);
        check("out_src", os2, src_of(e.dst));
        check("out_data", ox2, data_of(e.dst));
        last_src = int'(e.dst[16]);
        cnt[last_src]++;
      end
    end
    @(posedge clk);
    #1;
    if (fired) begin
      if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      if (h.cmd[22]) begin
        m_locked = 1'b0;
        m_ptr    = 1 - g;
      end else begin
        m_locked = 1'b1;
        m_lid    = g;
      end
    end
  endtask

  task automatic run(input int maxc, output int n);
    bit fb;
    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < maxc) begin
      cycle(fb);
      n++;
    end
    check("drain", q0.size() + q1.size(), 0);
    check("sb_empty", exq.size(), 0);
  endtask

  initial begin
    int p4, g4;
    m_ptr = 0; m_lid = 0; m_locked = 1'b0; rnd = 1'b0; have_stall = 1'b0;
    seq = '{0, 0}; cnt = '{0, 0};
    v4 = '0; c4 = '0; d4 = '0; s4 = '0; x4 = '0; ordy4 = 1'b1;
    v2 = 2'b11; c2 = '0; s2 = '0; x2 = '0; ordy2 = 1'b1;
    d2 = {32'h0000_1111, 32'h0000_2222};

    // reset state: no grant, no ready, payload muxed from input 0
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", ov2, 1'b0);
    check("rst_in_ready", r2, 2'b00);
    check("rst_grant_id", gid2, 1'b0);
    check("rst_mux_in0", od2, 32'h0000_2222);
    check("rst_gid4", gid4, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin, 100 single-beat packets
    for (int k = 0; k < 50; k++) begin
      push_msg(0, 1);
      push_msg(1, 1);
    end
    run(400, used);
    check("rr_cycles", used, 100);
    check("rr_cnt0", cnt[0], 50);
    check("rr_cnt1", cnt[1], 50);

    // message lock: in0 3-beat message against continuously valid in1
    push_msg(0, 3);
    for (int k = 0; k < 3; k++) push_msg(1, 1);
    run(100, used);

    // idle within lock: in0 silent 5 cycles mid-message, in1 waiting
    push_beat(0, 1'b0);
    run(20, used);
    push_msg(1, 1);
    push_msg(1, 1);
    cnt = '{0, 0};
    for (int k = 0; k < 5; k++) cycle(f);
    check("idle_lock_in1_beats", cnt[1], 0);
    push_beat(0, 1'b1);
    run(20, used);

    // random backpressure with mixed message lengths
    rnd = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push_msg(0, $urandom_range(1, 3));
      push_msg(1, $urandom_range(1, 3));
    end
    run(2000, used);
    rnd = 1'b0;
    have_stall = 1'b0;

    // reset after beat 1 of a 3-beat in1 message
    push_msg(1, 3);
    cycle(f);
    check("pre_rst_first_src", last_src, 1);
    push_msg(0, 1);
    push_msg(0, 1);
    drive();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", ov2, 1'b0);
    check("midrst_in_ready", r2, 2'b00);
    check("midrst_grant_id", gid2, 1'b0);
    check("midrst_mux_in0", od2, d2[0 +: AW]);
    q1.delete();
    exq.delete();
    m_ptr = 0; m_locked = 1'b0; have_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_msg(1, 1);
    cycle(f);
    check("post_rst_first_src", last_src, 0);
    run(20, used);

    // N=4 fairness: only inputs 1 and 3 valid, single-beat packets
    for (int i = 0; i < 4; i++) begin
      c4[i*CW +: CW] = 32'h0040_0004;
      d4[i*AW +: AW] = 32'(i);
      s4[i*AW +: AW] = src_of(32'(i));
      x4[i*DW +: DW] = data_of(32'(i));
    end
    p4 = 0;
    for (int k = 0; k < 8; k++) begin
      v4 = 4'b1010;
      g4 = -1;
      for (int j = 0; j < 4; j++)
        if (g4 < 0 && v4[(p4 + j) % 4]) g4 = (p4 + j) % 4;
      exq4.push_back(g4);
      p4 = (g4 + 1) % 4;
      @(negedge clk);
      g4 = exq4.pop_front();
      check("n4_out_valid", ov4, 1'b1);
      check("n4_grant_id", gid4, g4);
      check("n4_src", od4, g4);
      check("n4_ready", r4, 4'b0001 << g4);
      @(posedge clk);
      #1;
    end
    v4 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
